pc_sequencer: RTL and testbench

- Drives the program counter's write side: generates PC_In/PC_En each cycle from the current PC_Out, branch redirects, decode stalls and the instruction-memory handshake.
- Sits in the fetch stage between the hazard/execute redirect logic and program_counter.
- Owns the fetch request to instruction memory, holds redirects that arrive mid-fetch, and raises a sticky fault on timeout or misaligned target.

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM states, fault causes
// and the default reset vector / increment.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } pc_seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_TIMEOUT  = 2'd1,
    FC_MISALIGN = 2'd2
  } fault_cause_t;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          MAX_WAIT     = 15;

  // Redirect targets must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-stage PC write-side sequencer: produces PC_In/PC_En from the current PC,
// redirects, stalls and the instruction-memory handshake; flags sticky faults.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = pc_sequencer_pkg::RESET_VECTOR,
  parameter logic [31:0] PC_INC       = pc_sequencer_pkg::PC_INC,
  parameter int          MAX_WAIT     = pc_sequencer_pkg::MAX_WAIT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_Out,
  input  logic        Stall_F,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        IMem_Ready,
  output logic [31:0] PC_In,
  output logic        PC_En,
  output logic        IMem_Req,
  output logic        Flush_F,
  output logic        Fetch_Fault,
  output logic [1:0]  Fault_Cause
);
  import pc_sequencer_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  pc_seq_state_t state_q, state_d;
  fault_cause_t  cause_q, cause_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;

  logic [31:0] pc_in_s;
  logic        pc_en_s;
  logic        imem_req_s;
  logic        flush_s;
  logic        bad_redirect_s;
  logic [CNT_W-1:0] wait_inc_s;

  assign bad_redirect_s = Branch_Taken && is_misaligned(Branch_Target);
  assign wait_inc_s     = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= BOOT;
      cause_q    <= FC_NONE;
      wait_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wait_cnt_d = wait_cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pc_in_s    = PC_Out;
    pc_en_s    = 1'b0;
    imem_req_s = 1'b0;
    flush_s    = 1'b0;

    case (state_q)
      BOOT: begin
        pc_en_s    = 1'b1;
        pc_in_s    = RESET_VECTOR;
        wait_cnt_d = '0;
        state_d    = FETCH;
      end

      FETCH: begin
        imem_req_s = 1'b1;
        if (bad_redirect_s) begin
          state_d = FAULT;
          cause_d = FC_MISALIGN;
        end else if (!IMem_Ready) begin
          wait_cnt_d = wait_inc_s;
          if (wait_inc_s == CNT_W'(MAX_WAIT)) begin
            state_d = FAULT;
            cause_d = FC_TIMEOUT;
          end else begin
            state_d = FETCH;
          end
          // A redirect mid-fetch waits for the in-flight request; later ones are wrong-path.
          if (Branch_Taken && !pend_q) begin
            pend_d     = 1'b1;
            pend_tgt_d = Branch_Target;
          end else begin
            pend_d     = pend_q;
          end
        end else begin
          wait_cnt_d = '0;
          if (pend_q) begin
            pc_en_s = 1'b1;
            pc_in_s = pend_tgt_q;
            flush_s = 1'b1;
            pend_d  = 1'b0;
          end else if (Branch_Taken) begin
            pc_en_s = 1'b1;
            pc_in_s = Branch_Target;
            flush_s = 1'b1;
          end else if (!Stall_F) begin
            pc_en_s = 1'b1;
            pc_in_s = PC_Out + PC_INC;
          end else begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        wait_cnt_d = '0;
        if (bad_redirect_s) begin
          state_d = FAULT;
          cause_d = FC_MISALIGN;
        end else if (Branch_Taken) begin
          pc_en_s = 1'b1;
          pc_in_s = Branch_Target;
          flush_s = 1'b1;
          state_d = FETCH;
        end else if (!Stall_F) begin
          pc_en_s = 1'b1;
          pc_in_s = PC_Out + PC_INC;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = FAULT;
      end
    endcase

    if (!RST) begin
      pc_in_s    = RESET_VECTOR;
      pc_en_s    = 1'b0;
      imem_req_s = 1'b0;
      flush_s    = 1'b0;
    end else begin
      pc_in_s    = pc_in_s;
    end
  end

  assign PC_In       = pc_in_s;
  assign PC_En       = pc_en_s;
  assign IMem_Req    = imem_req_s;
  assign Flush_F     = flush_s;
  assign Fetch_Fault = RST && (state_q == FAULT);
  assign Fault_Cause = RST ? cause_q : FC_NONE;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a behavioural program counter.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic        stall_f;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_req;
  logic        flush_f;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int checks_q;
  int errors_q;

  pc_sequencer dut (
    .CLK           (clk),
    .RST           (rst),
    .PC_Out        (pc_out),
    .Stall_F       (stall_f),
    .Branch_Taken  (branch_taken),
    .Branch_Target (branch_target),
    .IMem_Ready    (imem_ready),
    .PC_In         (pc_in),
    .PC_En         (pc_en),
    .IMem_Req      (imem_req),
    .Flush_F       (flush_f),
    .Fetch_Fault   (fetch_fault),
    .Fault_Cause   (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for program_counter: loads PC_In one edge after PC_En.
  always @(posedge clk) begin
    if (pc_en) pc_out <= pc_in;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {PC_En, IMem_Req, Flush_F, Fetch_Fault, Fault_Cause}
  function automatic logic [31:0] ctl();
    return {26'd0, pc_en, imem_req, flush_f, fetch_fault, fault_cause};
  endfunction

  initial begin
    checks_q      = 0;
    errors_q      = 0;
    pc_out        = 32'h1234_5670;
    rst           = 1'b0;
    stall_f       = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b1;
    step();
    step();
    check_val("reset_ctl", ctl(), 32'h00);
    check_val("reset_pcin", pc_in, 32'h0);

    // Boot then sequential fetch
    rst = 1'b1;
    #1;
    check_val("boot_ctl", ctl(), 32'h20);
    check_val("boot_pcin", pc_in, 32'h0);
    step();
    check_val("seq_pc0", pc_out, 32'h0);
    check_val("seq_ctl", ctl(), 32'h30);
    check_val("seq_pcin4", pc_in, 32'h4);
    step();
    check_val("seq_pc4", pc_out, 32'h4);
    check_val("seq_pcin8", pc_in, 32'h8);
    step();
    check_val("seq_pc8", pc_out, 32'h8);
    step();
    check_val("seq_pc12", pc_out, 32'hC);

    // Wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    #1;
    check_val("br_flush_ctl", ctl(), 32'h38);
    step();
    branch_taken = 1'b0;
    #1;
    check_val("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check_val("wrap_pcin", pc_in, 32'h0);
    check_val("wrap_ctl", ctl(), 32'h30);
    step();
    check_val("wrap_pc0", pc_out, 32'h0);

    // Redirect arrives while memory is not ready
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    check_val("pend_ctl0", ctl(), 32'h10);
    step();
    branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    check_val("pend_ctl1", ctl(), 32'h10);
    step();
    branch_taken = 1'b0;
    step();
    check_val("pend_pc_hold", pc_out, 32'h0);
    imem_ready = 1'b1;
    #1;
    check_val("pend_pcin", pc_in, 32'h100);
    check_val("pend_flush_ctl", ctl(), 32'h38);
    step();
    check_val("pend_pc", pc_out, 32'h100);
    check_val("pend_flush_once", ctl(), 32'h30);
    check_val("pend_next", pc_in, 32'h104);

    // Stall into HOLD for five cycles
    stall_f = 1'b1;
    #1;
    check_val("stall_fetch_ctl", ctl(), 32'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("hold_ctl", ctl(), 32'h00);
      check_val("hold_pc", pc_out, 32'h100);
    end
    stall_f = 1'b0;
    #1;
    check_val("unstall_ctl", ctl(), 32'h20);
    check_val("unstall_pcin", pc_in, 32'h104);
    step();
    check_val("unstall_pc", pc_out, 32'h104);
    stall_f = 1'b1;
    step();
    branch_taken = 1'b1; branch_target = 32'h200;
    #1;
    check_val("hold_br_ctl", ctl(), 32'h28);
    check_val("hold_br_pcin", pc_in, 32'h200);
    step();
    branch_taken = 1'b0; stall_f = 1'b0;
    #1;
    check_val("hold_br_pc", pc_out, 32'h200);
    check_val("hold_br_fetch", ctl(), 32'h30);

    // Misaligned redirect
    branch_taken = 1'b1; branch_target = 32'h102;
    #1;
    check_val("mis_no_load", ctl(), 32'h10);
    step();
    branch_taken = 1'b0;
    #1;
    check_val("mis_fault_ctl", ctl(), 32'h06);
    step();
    check_val("mis_pc", pc_out, 32'h200);
    check_val("mis_sticky", ctl(), 32'h06);
    rst = 1'b0;
    #1;
    check_val("mis_rst_ctl", ctl(), 32'h00);
    step();
    rst = 1'b1;
    step();
    check_val("rst2_pc", pc_out, 32'h0);

    // Timeout after MAX_WAIT not-ready cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_val("wait14_ctl", ctl(), 32'h10);
    step();
    check_val("timeout_ctl", ctl(), 32'h05);
    step();
    check_val("timeout_pc", pc_out, 32'h0);
    rst = 1'b0;
    #1;
    check_val("timeout_rst_ctl", ctl(), 32'h00);
    check_val("timeout_rst_pcin", pc_in, 32'h0);
    step();
    rst = 1'b1; imem_ready = 1'b1;
    #1;
    check_val("reboot_ctl", ctl(), 32'h20);
    step();
    check_val("reboot_fetch", ctl(), 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule
